// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// controller state encoding and the source-count ceiling.
package irq_ctrl_pkg;

    localparam int NSRC_MAX = 8;

    localparam logic [1:0] IC_MASK  = 2'd0;
    localparam logic [1:0] IC_PEND  = 2'd1;
    localparam logic [1:0] IC_MODE  = 2'd2;
    localparam logic [1:0] IC_CLAIM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } ic_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 is the most urgent source.
module irq_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [2:0]   idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid_o = |req_i;
        idx_o   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source requests into PENDING, masks them,
// presents one IRQ at a time to CP0 and waits for an EOI write to CLAIM.
//
//  state  | meaning
//  IDLE   | no interrupt signalled; picks the best masked pending source
//  ACTIVE | IRQ held high for CUR until EOI or until MASK[CUR] drops
//  GAP    | one forced low cycle after EOI so CP0 sees a falling edge
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NSRC-1:0] SRC,
    input  logic [1:0]      innerADDR,
    input  logic            WE,
    input  logic [31:0]     WD,
    output logic [31:0]     RD,
    output logic            IRQ,
    output logic [2:0]      IRQ_ID
);

    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] src_d_q;
    logic [2:0]      cur_q;
    logic            irq_q;
    ic_state_e       state_q;

    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] cur_onehot;
    logic            sel_valid;
    logic [2:0]      sel_idx;
    logic            eoi;
    logic            cur_masked;
    logic            busy;
    logic            unused_wd;

    assign unused_wd  = &{1'b0, WD};
    assign cand       = pend_q & mask_q;
    assign cur_onehot = NSRC'(1) << cur_q;
    assign cur_masked = |(mask_q & cur_onehot);
    assign busy       = (state_q != ST_IDLE);
    assign eoi        = WE && (innerADDR == IC_CLAIM) && (state_q == ST_ACTIVE)
                        && (WD[2:0] == cur_q);

    irq_prio_enc #(.N(NSRC)) u_prio (
        .req_i   (cand),
        .valid_o (sel_valid),
        .idx_o   (sel_idx)
    );

    // Request capture and register writes; a set beats a clear on the same bit.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            set_vec[i] = mode_q[i] ? (SRC[i] & ~src_d_q[i]) : SRC[i];
        end
        clr_vec = '0;
        if (WE && (innerADDR == IC_PEND)) clr_vec = WD[NSRC-1:0];
        if (eoi) clr_vec = clr_vec | cur_onehot;
        pend_d = (pend_q & ~clr_vec) | set_vec;
        mask_d = (WE && (innerADDR == IC_MASK)) ? WD[NSRC-1:0] : mask_q;
        mode_d = (WE && (innerADDR == IC_MODE)) ? WD[NSRC-1:0] : mode_q;
    end

    // Register file and source history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mask_q  <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            src_d_q <= '0;
        end else begin
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            src_d_q <= SRC;
        end
    end

    // Controller FSM with registered IRQ and current-source index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cur_q   <= 3'd0;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        cur_q   <= sel_idx;
                        irq_q   <= 1'b1;
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (eoi) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_GAP;
                    end else if (!cur_masked) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    irq_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational register read-back; unused upper bits read zero.
    always_comb begin
        RD = 32'd0;
        case (innerADDR)
            IC_MASK:  RD = 32'(mask_q);
            IC_PEND:  RD = 32'(pend_q);
            IC_MODE:  RD = 32'(mode_q);
            IC_CLAIM: RD = 32'({busy, cur_q});
            default:  RD = 32'd0;
        endcase
    end

    assign IRQ    = irq_q;
    assign IRQ_ID = cur_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller between the timer/peripheral IRQ lines and the CPU's CP0 hardware-interrupt input.
- Latches up to NSRC source requests into a pending register, applies a mask, selects the highest-priority source, and holds a single IRQ to the CPU until software signals completion (EOI).
- Software accesses it through the same word-addressed bridge slot as the timers: base + innerADDR*4.

Parameters:
- NSRC, 6, number of interrupt sources (1..8); source 0 has the highest priority.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- SRC  input  NSRC  raw interrupt lines from Timer IRQ outputs and peripherals, synchronous to CLK
- innerADDR  input  2  0=MASK, 1=PENDING, 2=MODE, 3=CLAIM
- WE  input  1  register write strobe
- WD  input  32  write data
- RD  output  32  read data, combinational from innerADDR
- IRQ  output  1  interrupt request to CP0
- IRQ_ID  output  3  index of the source being signalled; valid while IRQ=1

Behaviour:
- Reset (asynchronous, any state): MASK=0, PENDING=0, MODE=0, SRC_d=0, STATE=IDLE, CUR=0, IRQ=0, IRQ_ID=0.
- MODE[i]: 1=edge-triggered (rising edge of SRC[i] versus the registered copy SRC_d[i]); 0=level-triggered.
- Pending set, every cycle: PENDING[i] <= 1 on an edge (edge mode) or while SRC[i]=1 (level mode).
- Pending clear:
  - Write to PENDING: write-1-to-clear, using WD[NSRC-1:0].
  - EOI for source CUR clears PENDING[CUR].
  - A set and a clear on the same bit in the same cycle: the set wins.
- Register reads; unused RD bits read 0:
  - MASK: RD = MASK.
  - PENDING: RD = PENDING.
  - MODE: RD = MODE.
  - CLAIM: RD = {28'b0, busy, CUR}, where busy = (STATE != IDLE).
- Writes to MASK and MODE take effect on the next cycle. Bits above NSRC-1 are ignored.
- Candidate set: cand = PENDING & MASK. Sel = lowest set index in cand.
- State machine:
  - IDLE: if cand != 0, then CUR <= Sel and go to ACTIVE. IRQ rises in the cycle after cand becomes nonzero (1-cycle latency).
  - ACTIVE: IRQ=1, IRQ_ID=CUR.
    - A write to CLAIM with WD[2:0]==CUR is EOI: clear PENDING[CUR], set IRQ <= 0, go to GAP.
    - A write to CLAIM with a different ID is ignored.
    - If MASK[CUR] is cleared while ACTIVE: drop IRQ and return to IDLE without clearing pending.
    - A higher-priority source arriving while ACTIVE does not pre-empt; it waits.
  - GAP: IRQ=0 for exactly one cycle, then IDLE. This guarantees CP0 sees a deasserted edge between interrupts.
- Level-mode source still high at EOI: it re-pends immediately and is signalled again after GAP, which is the correct re-trigger behaviour.
- IRQ and IRQ_ID are registered outputs. IRQ_ID holds CUR in every state.

Decomposition:
- Shared package/header: register-offset constants (IC_MASK=0, IC_PEND=1, IC_MODE=2, IC_CLAIM=3); state encodings (IDLE, ACTIVE, GAP); NSRC maximum.
- One sub-module: irq_prio_enc, a combinational NSRC-bit lowest-index priority encoder producing {valid, index}.

Test Plan:
1. Reset mid-ACTIVE: RST pulse between clock edges → IRQ=0 immediately; all registers read 0.
2. MASK=6'b000010, MODE=0, SRC[1]=1 at cycle t → IRQ=1 and IRQ_ID=1 at t+1; CLAIM reads 0x9. Then write CLAIM=1 → IRQ=0 for the one GAP cycle, then IRQ=1 again while SRC[1] stays high.
3. Edge mode, MODE=6'b000100, MASK=6'b000100, single-cycle pulse on SRC[2] → PENDING reads 0x4; IRQ_ID=2. Write CLAIM=2 → PENDING=0 and IRQ stays 0.
4. Priority: SRC[4] and SRC[0] asserted together, MASK=0x3F → IRQ_ID=0 first. After EOI(0) and GAP → IRQ_ID=4. A write CLAIM=4 issued while CUR=0 is ignored.
5. Collision and W1C: write PENDING=0x8 in the same cycle a level SRC[3]=1 is sampled → PENDING[3] remains 1. Write PENDING=0x3F with all SRC low → PENDING=0.
6. Mask while ACTIVE: CUR=5, then write MASK=0 → IRQ drops next cycle, state returns to IDLE, PENDING[5] is still 1. Restoring MASK=0x20 → IRQ re-asserts with IRQ_ID=5.
